// File: rtl/regfile_multiport.sv
// Parametrised integer register file: NUM_RD combinational read ports, one write port, r0 = 0,
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module regfile_multiport #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_RD*AW-1:0]   addr_rs,
  output logic [NUM_RD*XLEN-1:0] data_rs,
  output logic [NUM_RD-1:0]      busy_rs,
  input  logic [AW-1:0]          addr_rd,
  input  logic [XLEN-1:0]        data_rd,
  input  logic                   write_enable,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  output logic                   busy_any
);

  // Register 0 has no storage; entries and busy bits start at index 1.
  logic [XLEN-1:0]     mem_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] busy_q, busy_d;
  logic [NUM_REGS-1:1] wr_hit, iss_hit;

  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      wr_hit[r]  = write_enable && (addr_rd == AW'(r));
      iss_hit[r] = issue_valid && (issue_rd == AW'(r));
    end
  end

  // A new producer outranks the retiring one on the same register.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (iss_hit[r]) begin
        busy_d[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          mem_q[r] <= data_rd;
        end
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    data_rs = '0;
    busy_rs = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (addr_rs[k*AW +: AW] == AW'(r)) begin
          data_rs[k*XLEN +: XLEN] = mem_q[r];
          busy_rs[k]              = busy_q[r];
`ifdef REGFILE_BYPASS_EN
          if (wr_hit[r]) begin
            data_rs[k*XLEN +: XLEN] = data_rd;
            busy_rs[k]              = 1'b0;
          end
`endif
        end
      end
    end
  end

  assign busy_any = |busy_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a 32x32/3-read instance and a 16x64/4-read instance.
module tb_regfile_multiport;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Instance A: XLEN=32, NUM_REGS=32, NUM_RD=3
  logic [14:0] a_addr_rs;
  logic [95:0] a_data_rs;
  logic [2:0]  a_busy_rs;
  logic [4:0]  a_addr_rd, a_issue_rd;
  logic [31:0] a_data_rd;
  logic        a_we, a_iv, a_busy_any;

  // Instance B: XLEN=64, NUM_REGS=16, NUM_RD=4
  logic [15:0]  b_addr_rs;
  logic [255:0] b_data_rs;
  logic [3:0]   b_busy_rs;
  logic [3:0]   b_addr_rd, b_issue_rd;
  logic [63:0]  b_data_rd;
  logic         b_we, b_iv, b_busy_any;

  regfile_multiport #(.XLEN(32), .NUM_REGS(32), .NUM_RD(3)) u_dut_a (
    .clock(clock), .reset(reset), .addr_rs(a_addr_rs), .data_rs(a_data_rs),
    .busy_rs(a_busy_rs), .addr_rd(a_addr_rd), .data_rd(a_data_rd), .write_enable(a_we),
    .issue_valid(a_iv), .issue_rd(a_issue_rd), .busy_any(a_busy_any)
  );

  regfile_multiport #(.XLEN(64), .NUM_REGS(16), .NUM_RD(4)) u_dut_b (
    .clock(clock), .reset(reset), .addr_rs(b_addr_rs), .data_rs(b_data_rs),
    .busy_rs(b_busy_rs), .addr_rd(b_addr_rd), .data_rd(b_data_rd), .write_enable(b_we),
    .issue_valid(b_iv), .issue_rd(b_issue_rd), .busy_any(b_busy_any)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic a_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir);
    a_we = we; a_addr_rd = wa; a_data_rd = wd; a_iv = iv; a_issue_rd = ir;
  endtask

  task automatic b_drive(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                         input logic iv, input logic [3:0] ir);
    b_we = we; b_addr_rd = wa; b_data_rd = wd; b_iv = iv; b_issue_rd = ir;
  endtask

  initial begin
    a_addr_rs = '0;
    b_addr_rs = '0;
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    b_drive(1'b0, 4'd0, 64'h0, 1'b0, 4'd0);
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset state
    a_addr_rs = {5'd3, 5'd2, 5'd1};
    #1;
    check("a_reset_data", {32'h0, a_data_rs[31:0]}, 64'h0);
    check("a_reset_busy", {61'h0, a_busy_rs}, 64'h0);
    check("a_reset_busy_any", {63'h0, a_busy_any}, 64'h0);

    // Reset asserted between a write and its edge
    a_drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6);
    step();
    a_addr_rs = {5'd0, 5'd6, 5'd5};
    a_drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    #1;
    check("a_pre_reset_r5", {32'h0, a_data_rs[31:0]}, 64'h55);
    check("a_pre_reset_busy_any", {63'h0, a_busy_any}, 64'h1);
    #1 reset = 1'b1;
    step();
    check("a_rst_held_r5", {32'h0, a_data_rs[31:0]}, 64'h0);
    check("a_rst_held_busy", {61'h0, a_busy_rs}, 64'h0);
    check("a_rst_held_busy_any", {63'h0, a_busy_any}, 64'h0);
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    reset = 1'b0;
    step();
    check("a_post_rst_r5", {32'h0, a_data_rs[31:0]}, 64'h0);
    check("a_post_rst_busy_any", {63'h0, a_busy_any}, 64'h0);

    // Register 0 ignores writes and issues
    a_drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    a_addr_rs = {5'd0, 5'd0, 5'd0};
    #1;
    check("a_r0_data", {32'h0, a_data_rs[31:0]}, 64'h0);
    check("a_r0_busy", {63'h0, a_busy_rs[0]}, 64'h0);
    check("a_r0_busy_any", {63'h0, a_busy_any}, 64'h0);

    // Multiport read
    a_drive(1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
    step();
    a_drive(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    a_addr_rs = {5'd0, 5'd31, 5'd1};
    #1;
    check("a_mp_p0_r1", {32'h0, a_data_rs[31:0]}, 64'h11);
    check("a_mp_p1_r31", {32'h0, a_data_rs[63:32]}, 64'hFFFFFFFF);
    check("a_mp_p2_r0", {32'h0, a_data_rs[95:64]}, 64'h0);

    // Scoreboard: issue r7, write it back three cycles later
    a_addr_rs = {5'd0, 5'd0, 5'd7};
    a_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    #1;
    check("a_sb_pre_issue", {63'h0, a_busy_rs[0]}, 64'h0);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("a_sb_n1", {63'h0, a_busy_rs[0]}, 64'h1);
    check("a_sb_any", {63'h0, a_busy_any}, 64'h1);
    step();
    check("a_sb_n2", {63'h0, a_busy_rs[0]}, 64'h1);
    step();
    a_drive(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("a_sb_n3_busy", {63'h0, a_busy_rs[0]}, 64'h0);
`else
    check("a_sb_n3_busy", {63'h0, a_busy_rs[0]}, 64'h1);
`endif
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("a_sb_n4_busy", {63'h0, a_busy_rs[0]}, 64'h0);
    check("a_sb_n4_data", {32'h0, a_data_rs[31:0]}, 64'hA5);
    check("a_sb_n4_any", {63'h0, a_busy_any}, 64'h0);

    // Simultaneous issue and write on a busy register: stays busy, data updates
    a_addr_rs = {5'd0, 5'd0, 5'd9};
    a_drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    step();
    a_drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("a_sim_r9_busy", {63'h0, a_busy_rs[0]}, 64'h1);
    check("a_sim_r9_data", {32'h0, a_data_rs[31:0]}, 64'h99);
    a_drive(1'b1, 5'd9, 32'h9A, 1'b0, 5'd0);
    step();
    check("a_r9_cleared", {63'h0, a_busy_rs[0]}, 64'h0);
    a_addr_rs = {5'd0, 5'd4, 5'd3};
    a_drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd3);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("a_diff_r3_busy", {63'h0, a_busy_rs[0]}, 64'h1);
    check("a_diff_r4_busy", {63'h0, a_busy_rs[1]}, 64'h0);
    check("a_diff_r4_data", {32'h0, a_data_rs[63:32]}, 64'h44);

    // Bypass: port 1 reads r12 (value 1, busy) during the write of 0xCAFE
    a_drive(1'b1, 5'd12, 32'h1, 1'b1, 5'd12);
    step();
    a_addr_rs = {5'd3, 5'd12, 5'd0};
    a_drive(1'b1, 5'd12, 32'hCAFE, 1'b0, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("a_byp_data", {32'h0, a_data_rs[63:32]}, 64'hCAFE);
    check("a_byp_busy", {63'h0, a_busy_rs[1]}, 64'h0);
`else
    check("a_byp_data", {32'h0, a_data_rs[63:32]}, 64'h1);
    check("a_byp_busy", {63'h0, a_busy_rs[1]}, 64'h1);
`endif
    check("a_byp_other_port", {63'h0, a_busy_rs[2]}, 64'h1);
    step();
    a_drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    check("a_byp_next_data", {32'h0, a_data_rs[63:32]}, 64'hCAFE);
    check("a_byp_next_busy", {63'h0, a_busy_rs[1]}, 64'h0);

    // Instance B: wide data, 16 registers, 4 read ports
    b_drive(1'b1, 4'd15, 64'hFEDC_BA98_7654_3210, 1'b0, 4'd0);
    step();
    b_drive(1'b1, 4'd1, 64'h1, 1'b1, 4'd7);
    step();
    b_drive(1'b1, 4'd0, 64'h12345678, 1'b1, 4'd0);
    b_addr_rs = {4'd7, 4'd0, 4'd1, 4'd15};
    #1;
    check("b_p0_r15", b_data_rs[63:0], 64'hFEDC_BA98_7654_3210);
    check("b_p1_r1", b_data_rs[127:64], 64'h1);
    check("b_p3_r7_busy", {60'h0, b_busy_rs}, 64'h8);
    check("b_busy_any", {63'h0, b_busy_any}, 64'h1);
    step();
    check("b_p2_r0_data", b_data_rs[191:128], 64'h0);
    check("b_p2_r0_busy", {63'h0, b_busy_rs[2]}, 64'h0);
    b_drive(1'b1, 4'd7, 64'hA5, 1'b0, 4'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("b_byp_data", b_data_rs[255:192], 64'hA5);
    check("b_byp_busy", {63'h0, b_busy_rs[3]}, 64'h0);
`else
    check("b_byp_data", b_data_rs[255:192], 64'h0);
    check("b_byp_busy", {63'h0, b_busy_rs[3]}, 64'h1);
`endif
    step();
    b_drive(1'b0, 4'd0, 64'h0, 1'b0, 4'd0);
    check("b_r7_data", b_data_rs[255:192], 64'hA5);
    check("b_r7_busy_any", {63'h0, b_busy_any}, 64'h0);

    // Instance B: reset mid-write
    b_drive(1'b1, 4'd15, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 4'd2);
    #2 reset = 1'b1;
    step();
    b_drive(1'b0, 4'd0, 64'h0, 1'b0, 4'd0);
    reset = 1'b0;
    step();
    check("b_rst_r15", b_data_rs[63:0], 64'h0);
    check("b_rst_busy_any", {63'h0, b_busy_any}, 64'h0);
    check("a_rst_r12", {32'h0, a_data_rs[63:32]}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised integer register file for the five-stage core, generalising the fixed two-read/one-write, 32×32 register file. It provides N combinational read ports, one synchronous write port from writeback, a hardwired-zero register 0, and a per-register busy scoreboard. Decode uses the scoreboard to stall on read-after-write hazards. It sits between decode (reads, issue) and writeback (write, busy clear).

## Interface
- `XLEN`, 32: data width per register.
- `NUM_REGS`, 32: architectural register count; power of two, ≥2.
- `NUM_RD`, 2: number of read ports, 1–4.
- `AW`, `$clog2(NUM_REGS)`: address width (derived; do not override).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears registers and scoreboard.
- `addr_rs` in `NUM_RD*AW`: packed read addresses; port k is bits `[k*AW +: AW]`.
- `data_rs` out `NUM_RD*XLEN`: packed read data; port k is bits `[k*XLEN +: XLEN]`.
- `busy_rs` out `NUM_RD`: bit k = 1 when port k's register has a pending write.
- `addr_rd` in `AW`: write address.
- `data_rd` in `XLEN`: write data.
- `write_enable` in 1: write `data_rd` to `addr_rd` at the clock edge; also clears busy for `addr_rd`.
- `issue_valid` in 1: decode issued an instruction that will write `issue_rd`.
- `issue_rd` in `AW`: destination of the issued instruction; sets its busy bit.
- `busy_any` out 1: OR of all busy bits (pipeline drain / fence).

## Operation
- Storage: `NUM_REGS-1` entries for registers 1..`NUM_REGS-1`. Register 0 has no storage.
- Read: `data_rs[k]` is combinational from `addr_rs[k]`. Address 0 → 0.
- Write: on the rising edge, if `write_enable` and `addr_rd != 0`, the entry takes `data_rd`. Writes to 0 are discarded.
- Scoreboard: `busy[NUM_REGS-1:1]`; `busy[0]` is constant 0.
  - Rising edge with `issue_valid && issue_rd != 0` → `busy[issue_rd] <= 1`.
  - Rising edge with `write_enable && addr_rd != 0` → `busy[addr_rd] <= 0`.
  - Same edge, same nonzero register, both asserted → busy ends 1. The new producer wins over the retiring one.
  - Same edge, different registers → both updates apply.
- `busy_rs[k] = busy[addr_rs[k]]`, with bypass adjustment (see Configuration). `busy_any = |busy`.
- Scoreboard holds one bit per register, so only one outstanding producer per register is tracked. Decode must not issue a second writer to a busy register. Behaviour in that case is undefined for verification; no assertion is required.

## Timing
- Reset (asynchronous assert, any time, including mid-write): all entries = 0, all busy = 0. Therefore `data_rs` = 0, `busy_rs` = 0, `busy_any` = 0 while reset is held and after release.
- Read latency: 0 cycles (combinational). Write latency: visible at the next edge without bypass.
- Issue → busy visible: 1 cycle. Write → busy cleared: 1 cycle.
- No handshake, no backpressure; every write and issue is accepted.
- Write and read of the same address in the same cycle: without bypass, the old value is returned.

## Configuration
- `REGFILE_BYPASS_EN` defined: same-cycle write-through forwarding.
  - If `write_enable && addr_rd != 0 && addr_rd == addr_rs[k]`, then `data_rs[k] = data_rd` and `busy_rs[k] = 0` in that same cycle.
  - Applies independently per port.
- Undefined: no forwarding. `data_rs[k]` shows stored contents only. `busy_rs[k]` clears one cycle after the write.

## Test plan
- Reset mid-write: write 0xDEADBEEF to r5 with `reset` rising before the edge → r5 reads 0; all `busy_rs` = 0; `busy_any` = 0.
- Register 0: write 0x12345678 to r0, issue r0 → port 0 on r0 reads 0; `busy_rs[0]` = 0; `busy_any` stays 0.
- Multiport read: write r1 = 0x11, r31 = 0xFFFFFFFF, then read r1 / r31 / r0 on ports 0/1/2 (`NUM_RD`=3) → 0x11 / 0xFFFFFFFF / 0.
- Scoreboard: issue r7 at cycle n → `busy_rs` = 1 for r7 from n+1. Write r7 = 0xA5 at cycle n+3 → busy 0 from n+4, and the read returns 0xA5.
- Simultaneous issue + write on r9 (busy before) → r9 stays busy and data updates. Issue r3 with write r4 → r3 busy, r4 clear.
- Bypass: write r12 = 0xCAFE while port 1 reads r12 (previously 0x1, busy). With `REGFILE_BYPASS_EN`: 0xCAFE and busy 0 in the same cycle. Without it: 0x1 and busy 1, then 0xCAFE and busy 0 next cycle.
- Parameter sweep: rerun the above with `XLEN`=64, `NUM_REGS`=16, `NUM_RD`=4 → identical behaviour, address width 4.
